alert_gen_shift_reg: RTL and testbench

//  Upstream producer for the butterfly mux controller. It buffers the first half-frame of complex

---
 rtl/alert_gen_shift_reg_if.sv | 23 ++
 rtl/alert_gen_shift_reg.sv | 128 ++++++++++++
 tb/tb_alert_gen_shift_reg.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alert_gen_shift_reg_if.sv
// Sample-stream bundle between the input source, the half-frame buffer and the butterfly stage.
interface alert_gen_shift_reg_if #(
  parameter int unsigned DATA_W = 9
);
  logic                     din_valid;
  logic signed [DATA_W-1:0] din_re;
  logic signed [DATA_W-1:0] din_im;
  logic signed [DATA_W-1:0] dout_re;
  logic signed [DATA_W-1:0] dout_im;
  logic                     alert_mod01;
  logic                     busy;
  logic                     frame_err;

  modport master (
    output din_valid, din_re, din_im,
    input  dout_re, dout_im, alert_mod01, busy, frame_err
  );

  modport slave (
    input  din_valid, din_re, din_im,
    output dout_re, dout_im, alert_mod01, busy, frame_err
  );
endinterface

// File: rtl/alert_gen_shift_reg.sv
// Buffers a half-frame of complex samples, pulses alert_mod01, then streams 2*DEPTH samples.
// Define FRAME_ERR_EN to build the sticky frame_err protocol checker; otherwise it is tied to 0.
module alert_gen_shift_reg #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 16
) (
  input logic                 clk,
  input logic                 rstn,
  alert_gen_shift_reg_if.slave bus
);
  localparam int unsigned CntW = $clog2(2 * DEPTH) + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StFill   = 2'd1;
  localparam logic [1:0] StStream = 2'd2;

  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] FillLast   = CntW'(DEPTH - 1);
  localparam logic [CntW-1:0] Half       = CntW'(DEPTH);
  localparam logic [CntW-1:0] StreamLast = CntW'(2 * DEPTH - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            alert_q, alert_d;

  // sr[0] is the head (bits [DATA_W-1:0]), sr[DEPTH-1] the tail driving dout.
  logic [DEPTH-1:0][DATA_W-1:0] sr_re_q, sr_im_q;
  logic                         shift_en;
  logic [DATA_W-1:0]            shin_re, shin_im;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alert_d  = 1'b0;
    shift_en = 1'b0;
    shin_re  = '0;
    shin_im  = '0;
    case (state_q)
      StIdle: begin
        if (bus.din_valid) begin
          shift_en = 1'b1;
          shin_re  = bus.din_re;
          shin_im  = bus.din_im;
          cnt_d    = CntOne;
          state_d  = StFill;
        end
      end
      StFill: begin
        if (bus.din_valid) begin
          shift_en = 1'b1;
          shin_re  = bus.din_re;
          shin_im  = bus.din_im;
          if (cnt_q == FillLast) begin
            state_d = StStream;
            cnt_d   = '0;
            alert_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
      StStream: begin
        shift_en = 1'b1;
        // Second half-frame takes din (zero on a gap); the drain phase always shifts zeros.
        if (cnt_q < Half && bus.din_valid) begin
          shin_re = bus.din_re;
          shin_im = bus.din_im;
        end
        if (cnt_q == StreamLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alert_q <= alert_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_re_q <= '0;
      sr_im_q <= '0;
    end else if (shift_en) begin
      sr_re_q <= {sr_re_q[DEPTH-2:0], shin_re};
      sr_im_q <= {sr_im_q[DEPTH-2:0], shin_im};
    end
  end

  assign bus.dout_re     = sr_re_q[DEPTH-1];
  assign bus.dout_im     = sr_im_q[DEPTH-1];
  assign bus.alert_mod01 = alert_q;
  assign bus.busy        = (state_q == StStream);

`ifdef FRAME_ERR_EN
  logic frame_err_q;

  // Gap in the second half or a sample offered during the drain; sticky until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err_q <= 1'b0;
    end else if (state_q == StStream &&
                 ((cnt_q < Half && !bus.din_valid) || (cnt_q >= Half && bus.din_valid))) begin
      frame_err_q <= 1'b1;
    end
  end

  assign bus.frame_err = frame_err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_alert_gen_shift_reg.sv
// Directed bench for alert_gen_shift_reg: fill, stream, gaps, overrun and mid-frame reset.
module tb_alert_gen_shift_reg;
  localparam int unsigned DATA_W = 9;
  localparam int unsigned DEPTH  = 16;

`ifdef FRAME_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  alert_gen_shift_reg_if #(.DATA_W(DATA_W)) bus ();

  alert_gen_shift_reg #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  logic err_exp  = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int val);
    bus.din_valid = v;
    bus.din_re    = DATA_W'(val);
    bus.din_im    = DATA_W'(-val);
  endtask

  task automatic check_out(input string tag, input int val, input logic alert, input logic busy);
    check({tag, ".re"}, bus.dout_re, val);
    check({tag, ".im"}, bus.dout_im, -val);
    check({tag, ".alert"}, bus.alert_mod01, alert);
    check({tag, ".busy"}, bus.busy, busy);
    check({tag, ".err"}, bus.frame_err, err_exp);
  endtask

  task automatic do_reset(input string tag);
    drive(1'b0, 0);
    #2 rstn = 1'b0;
    err_exp = 1'b0;
    #1 check_out({tag, ".rst"}, 0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Expected dout for stream slot s; a second-half gap at gap_slot yields 0 and delays the rest.
  function automatic int slot_val(input int base, input int gap_slot, input int s);
    if (s < 16 || gap_slot < 0 || s < gap_slot) return base + s;
    if (s == gap_slot) return 0;
    return base + s - 1;
  endfunction

  // First half-frame; gaps[k] inserts one invalid cycle before sample k.
  task automatic fill(input string tag, input int base, input logic [15:0] gaps);
    for (int k = 0; k < 16; k++) begin
      if (gaps[k]) begin
        drive(1'b0, 0);
        tick();
        check_out({tag, ".gap"}, 0, 1'b0, 1'b0);
      end
      drive(1'b1, base + k);
      tick();
      if (k == 15) check_out({tag, ".alert_edge"}, base, 1'b1, 1'b1);
      else         check_out({tag, ".fill"}, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic stream(input string tag, input int base, input int gap_slot,
                        input logic overrun, input int n_edges);
    int shift;
    shift = 0;
    for (int c = 0; c < n_edges; c++) begin
      if (c < 16) begin
        if (16 + c == gap_slot) begin
          drive(1'b0, 0);
          shift = 1;
          if (ErrEn) err_exp = 1'b1;
        end else begin
          drive(1'b1, base + 16 + c - shift);
        end
      end else begin
        drive(overrun, base + 16 + c - shift);
        if (overrun && ErrEn) err_exp = 1'b1;
      end
      tick();
      if (c == 31) check_out({tag, ".end"}, 0, 1'b0, 1'b0);
      else         check_out({tag, ".slot"}, slot_val(base, gap_slot, c + 1), 1'b0, 1'b1);
    end
  endtask

  initial begin
    drive(1'b0, 0);
    bus.din_valid = 1'b0;

    // 1: reset and idle with no valid
    #12 check_out("t1.rst", 0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("t1.idle", 0, 1'b0, 1'b0);
    end

    // 2: contiguous 32-sample frame
    fill("t2", 0, 16'h0000);
    stream("t2", 0, -1, 1'b0, 32);
    drive(1'b0, 0);
    tick();
    check_out("t2.idle", 0, 1'b0, 1'b0);

    // 3: three first-half gaps delay the alert only
    fill("t3", 0, 16'h1108);
    stream("t3", 0, -1, 1'b0, 32);

    // 4: second-half gap at sample 20
    fill("t4", 0, 16'h0000);
    stream("t4", 0, 20, 1'b0, 32);

    // 5: 64 back-to-back valids; 32..47 dropped in the drain, 48.. start the next frame
    do_reset("t5");
    fill("t5a", 0, 16'h0000);
    stream("t5a", 0, -1, 1'b1, 32);
    fill("t5b", 48, 16'h0000);
    stream("t5b", 48, -1, 1'b0, 32);

    // 6: reset at STREAM cnt=10, then a fresh frame
    do_reset("t6pre");
    fill("t6", 0, 16'h0000);
    stream("t6", 0, -1, 1'b0, 10);
    do_reset("t6");
    fill("t6b", 0, 16'h0000);
    stream("t6b", 0, -1, 1'b0, 32);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
